// File: rtl/conv3x3_stream.sv
// Streaming 3x3 convolution over a raster pixel stream: two internal line buffers
// build each window, one registered output pixel per full window, with backpressure.
module conv3x3_stream #(
    parameter int PIXEL_WIDTH = 8,
    parameter int IMG_W       = 252,
    parameter int IMG_H       = 252
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [1:0]             mode,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [PIXEL_WIDTH-1:0] in_pixel,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [PIXEL_WIDTH-1:0] out_pixel,
    output logic                   out_last
);

    localparam int ACC_W = PIXEL_WIDTH + 5;
    localparam int COL_W = (IMG_W > 1) ? $clog2(IMG_W) : 1;
    localparam int ROW_W = (IMG_H > 1) ? $clog2(IMG_H) : 1;

    localparam logic [COL_W-1:0] COL_ZERO  = {COL_W{1'b0}};
    localparam logic [ROW_W-1:0] ROW_ZERO  = {ROW_W{1'b0}};
    localparam logic [COL_W-1:0] COL_LAST  = COL_W'(IMG_W - 1);
    localparam logic [ROW_W-1:0] ROW_LAST  = ROW_W'(IMG_H - 1);
    localparam logic [COL_W-1:0] COL_FIRST = COL_W'(2);
    localparam logic [ROW_W-1:0] ROW_FIRST = ROW_W'(2);
    localparam logic [COL_W-1:0] COL_ONE   = COL_W'(1);
    localparam logic [ROW_W-1:0] ROW_ONE   = ROW_W'(1);

    localparam logic signed [ACC_W-1:0] PIX_MAX =
        $signed({{(ACC_W-PIXEL_WIDTH){1'b0}}, {PIXEL_WIDTH{1'b1}}});
    localparam logic signed [ACC_W-1:0] GAUSS_RND =
        $signed({{(ACC_W-4){1'b0}}, 4'b1000});

    typedef enum logic [1:0] {
        MODE_PASS    = 2'd0,
        MODE_SHARPEN = 2'd1,
        MODE_GAUSS   = 2'd2,
        MODE_EDGE    = 2'd3
    } mode_e;

    typedef struct packed {
        logic [PIXEL_WIDTH-1:0] top;
        logic [PIXEL_WIDTH-1:0] mid;
        logic [PIXEL_WIDTH-1:0] bot;
    } column_t;

    function automatic logic signed [ACC_W-1:0] widen(input logic [PIXEL_WIDTH-1:0] v);
        return $signed({{(ACC_W-PIXEL_WIDTH){1'b0}}, v});
    endfunction

    function automatic logic [PIXEL_WIDTH-1:0] clamp(input logic signed [ACC_W-1:0] v);
        logic [PIXEL_WIDTH-1:0] r;
        if (v[ACC_W-1]) begin
            r = {PIXEL_WIDTH{1'b0}};
        end else if (v > PIX_MAX) begin
            r = {PIXEL_WIDTH{1'b1}};
        end else begin
            r = v[PIXEL_WIDTH-1:0];
        end
        return r;
    endfunction

    logic [PIXEL_WIDTH-1:0] lb0_r [IMG_W];
    logic [PIXEL_WIDTH-1:0] lb1_r [IMG_W];

    logic [COL_W-1:0] col_r;
    logic [ROW_W-1:0] row_r;
    mode_e            mode_r;

    // Window: col_a_r is column c-2, col_b_r is c-1, the incoming column is c.
    column_t col_a_r;
    column_t col_b_r;
    column_t new_col_s;

    logic accept_s;
    logic col_end_s;
    logic frame_end_s;
    logic out_cond_s;

    logic signed [ACC_W-1:0] centre_s;
    logic signed [ACC_W-1:0] cross_s;
    logic signed [ACC_W-1:0] corner_s;
    logic signed [ACC_W-1:0] acc_s;
    logic [PIXEL_WIDTH-1:0]  result_s;

    assign in_ready    = !out_valid || out_ready;
    assign accept_s    = in_valid && in_ready;
    assign col_end_s   = (col_r == COL_LAST);
    assign frame_end_s = col_end_s && (row_r == ROW_LAST);
    assign out_cond_s  = (row_r >= ROW_FIRST) && (col_r >= COL_FIRST);
    assign new_col_s   = {lb1_r[col_r], lb0_r[col_r], in_pixel};

    assign centre_s = widen(col_b_r.mid);
    assign cross_s  = widen(col_b_r.top) + widen(col_b_r.bot)
                    + widen(col_a_r.mid) + widen(new_col_s.mid);
    assign corner_s = widen(col_a_r.top) + widen(col_a_r.bot)
                    + widen(new_col_s.top) + widen(new_col_s.bot);

    // Kernel evaluation for the frame's latched mode
    always_comb begin
        acc_s = centre_s;
        case (mode_r)
            MODE_PASS:    acc_s = centre_s;
            MODE_SHARPEN: acc_s = (centre_s <<< 2'd2) + centre_s - cross_s;
            MODE_GAUSS:   acc_s = (corner_s + (cross_s <<< 2'd1) + (centre_s <<< 2'd2)
                                   + GAUSS_RND) >>> 3'd4;
            MODE_EDGE:    acc_s = (centre_s <<< 2'd3) - cross_s - corner_s;
            default:      acc_s = centre_s;
        endcase
    end

    assign result_s = clamp(acc_s);

    // Raster position of the accepted pixel and per-frame mode capture
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            col_r  <= COL_ZERO;
            row_r  <= ROW_ZERO;
            mode_r <= MODE_PASS;
        end else if (accept_s) begin
            if (col_end_s) begin
                col_r <= COL_ZERO;
                if (row_r == ROW_LAST) begin
                    row_r <= ROW_ZERO;
                end else begin
                    row_r <= row_r + ROW_ONE;
                end
            end else begin
                col_r <= col_r + COL_ONE;
            end
            if ((col_r == COL_ZERO) && (row_r == ROW_ZERO)) begin
                mode_r <= mode_e'(mode);
            end
        end
    end

    // Line buffers: the previous line moves up one slot as the new pixel lands
    always_ff @(posedge clk) begin
        if (accept_s) begin
            lb1_r[col_r] <= lb0_r[col_r];
            lb0_r[col_r] <= in_pixel;
        end
    end

    // Window shift; stale columns from the prior line fall out before col 2
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            col_a_r <= {(3*PIXEL_WIDTH){1'b0}};
            col_b_r <= {(3*PIXEL_WIDTH){1'b0}};
        end else if (accept_s) begin
            col_a_r <= col_b_r;
            col_b_r <= new_col_s;
        end
    end

    // Single-entry output register: load on a full window, otherwise drain
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_pixel <= {PIXEL_WIDTH{1'b0}};
            out_last  <= 1'b0;
        end else if (accept_s && out_cond_s) begin
            out_valid <= 1'b1;
            out_pixel <= result_s;
            out_last  <= frame_end_s;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_conv3x3_stream.sv
// Scoreboard bench for conv3x3_stream: a 5x4 instance for the ramp frame and a
// 5x5 instance for kernels, clamping, backpressure, mode latching and reset.
module tb_conv3x3_stream;

    typedef struct packed {
        logic [7:0] pix;
        logic       last;
    } exp_t;

    logic clk;
    logic rst_n;

    // 5x5 instance
    logic [1:0] mode;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] in_pixel;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] out_pixel;
    logic       out_last;

    // 5x4 instance
    logic [1:0] a_mode;
    logic       a_in_valid;
    logic       a_in_ready;
    logic [7:0] a_in_pixel;
    logic       a_out_valid;
    logic       a_out_ready;
    logic [7:0] a_out_pixel;
    logic       a_out_last;

    int total;
    int bad;
    int beats_a;
    bit bp_en;
    bit stall_prev;
    logic [7:0] held_pix;
    logic       held_last;
    exp_t q_b[$];
    exp_t q_a[$];
    exp_t e_b;
    exp_t e_a;
    int img_b [25];

    conv3x3_stream #(.PIXEL_WIDTH(8), .IMG_W(5), .IMG_H(5)) u_b (
        .clk(clk), .rst_n(rst_n), .mode(mode),
        .in_valid(in_valid), .in_ready(in_ready), .in_pixel(in_pixel),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_pixel(out_pixel), .out_last(out_last)
    );

    conv3x3_stream #(.PIXEL_WIDTH(8), .IMG_W(5), .IMG_H(4)) u_a (
        .clk(clk), .rst_n(rst_n), .mode(a_mode),
        .in_valid(a_in_valid), .in_ready(a_in_ready), .in_pixel(a_in_pixel),
        .out_valid(a_out_valid), .out_ready(a_out_ready),
        .out_pixel(a_out_pixel), .out_last(a_out_last)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #500000;
        $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input int act, input int req);
        total++;
        if (act != req) begin
            bad++;
            $display("FAIL %s actual=%0d required=%0d", name, act, req);
        end
    endtask

    task automatic push_b(input int v, input bit last);
        exp_t e;
        e.pix  = 8'(v);
        e.last = last;
        q_b.push_back(e);
    endtask

    // Direct 3x3 convolution of img_b centred at (r,c)
    function automatic int conv_ref(input int r, input int c, input int m);
        int p [3][3];
        int sum;
        int acc;
        sum = 0;
        for (int i = 0; i < 3; i++) begin
            for (int j = 0; j < 3; j++) begin
                p[i][j] = img_b[(r - 1 + i) * 5 + (c - 1 + j)];
                sum += p[i][j];
            end
        end
        case (m)
            0: acc = p[1][1];
            1: acc = 5 * p[1][1] - p[0][1] - p[1][0] - p[1][2] - p[2][1];
            2: acc = (p[0][0] + 2 * p[0][1] + p[0][2] + 2 * p[1][0] + 4 * p[1][1]
                      + 2 * p[1][2] + p[2][0] + 2 * p[2][1] + p[2][2] + 8) / 16;
            3: acc = 9 * p[1][1] - sum;
            default: acc = 0;
        endcase
        if (acc < 0) acc = 0;
        if (acc > 255) acc = 255;
        return acc;
    endfunction

    // Backpressure generator, changes just after each rising edge
    initial begin
        out_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            out_ready = bp_en ? 1'($urandom_range(0, 1)) : 1'b1;
        end
    end

    // Monitor for the 5x5 instance: scoreboard pops and stall stability
    always @(negedge clk) begin
        if (rst_n) begin
            if (stall_prev && out_valid) begin
                check("stall_pix_held", int'(out_pixel), int'(held_pix));
                check("stall_last_held", int'(out_last), int'(held_last));
            end
            if (out_valid && out_ready) begin
                if (q_b.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL out_b_unexpected actual=%0d required=none", out_pixel);
                end else begin
                    e_b = q_b.pop_front();
                    check("out_b_pixel", int'(out_pixel), int'(e_b.pix));
                    check("out_b_last", int'(out_last), int'(e_b.last));
                end
            end
            if (out_valid && !out_ready) begin
                check("stall_in_ready", int'(in_ready), 0);
                held_pix   = out_pixel;
                held_last  = out_last;
                stall_prev = 1'b1;
            end else begin
                stall_prev = 1'b0;
            end
        end else begin
            stall_prev = 1'b0;
        end
    end

    // Monitor for the 5x4 instance
    always @(negedge clk) begin
        if (rst_n && a_out_valid && a_out_ready) begin
            beats_a++;
            if (q_a.size() == 0) begin
                total++;
                bad++;
                $display("FAIL out_a_unexpected actual=%0d required=none", a_out_pixel);
            end else begin
                e_a = q_a.pop_front();
                check("out_a_pixel", int'(a_out_pixel), int'(e_a.pix));
                check("out_a_last", int'(a_out_last), int'(e_a.last));
            end
        end
    end

    task automatic send(input logic [7:0] p);
        int guard;
        guard = 0;
        in_valid = 1'b1;
        in_pixel = p;
        @(negedge clk);
        while (!in_ready) begin
            @(negedge clk);
            guard++;
            if (guard > 200) begin
                $display("FAIL send_timeout actual=stalled required=accept");
                $fatal(1, "send timeout");
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic play_frame(input logic [1:0] m0, input logic [1:0] m1,
                              input int ref_mode, input bit model);
        for (int i = 0; i < 25; i++) begin
            mode = (i < 7) ? m0 : m1;
            if (model && (i / 5) >= 2 && (i % 5) >= 2) begin
                push_b(conv_ref(i / 5 - 1, i % 5 - 1, ref_mode), i == 24);
            end
            send(8'(img_b[i]));
        end
    endtask

    task automatic drain();
        int guard;
        guard = 0;
        in_valid = 1'b0;
        while ((q_b.size() != 0 || out_valid) && guard < 300) begin
            @(negedge clk);
            guard++;
        end
        check("drain_b_left", q_b.size(), 0);
        @(posedge clk);
        #1;
    endtask

    task automatic fill(input int v);
        for (int i = 0; i < 25; i++) img_b[i] = v;
    endtask

    task automatic fill_rand(input int lo);
        for (int i = 0; i < 25; i++) img_b[i] = int'($urandom_range(lo, 255));
    endtask

    initial begin
        total = 0; bad = 0; beats_a = 0; bp_en = 1'b0; stall_prev = 1'b0;
        mode = 2'd0; in_valid = 1'b0; in_pixel = 8'd0;
        a_mode = 2'd0; a_in_valid = 1'b0; a_in_pixel = 8'd0; a_out_ready = 1'b1;
        rst_n = 1'b1;
        #2 rst_n = 1'b0;
        #1;
        check("rst_out_valid", int'(out_valid), 0);
        check("rst_out_pixel", int'(out_pixel), 0);
        check("rst_out_last", int'(out_last), 0);
        check("rst_in_ready", int'(in_ready), 1);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Ramp through the 5x4 instance in pass mode
        for (int k = 0; k < 6; k++) begin
            e_a.pix  = (k < 3) ? 8'(6 + k) : 8'(8 + k);
            e_a.last = (k == 5);
            q_a.push_back(e_a);
        end
        for (int i = 0; i < 20; i++) begin
            a_in_valid = 1'b1;
            a_in_pixel = 8'(i);
            @(posedge clk);
            #1;
        end
        a_in_valid = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        check("ramp_beats", beats_a, 6);
        check("ramp_left", q_a.size(), 0);

        // Constant frames, gaussian then sharpen back to back
        for (int k = 0; k < 18; k++) push_b(100, (k % 9) == 8);
        fill(100);
        play_frame(2'd2, 2'd2, 2, 1'b0);
        play_frame(2'd1, 2'd1, 1, 1'b0);
        // Edge on a constant frame, then the clamp frame
        for (int k = 0; k < 9; k++) push_b(0, k == 8);
        for (int k = 0; k < 9; k++) push_b((k == 4) ? 255 : 0, k == 8);
        play_frame(2'd3, 2'd3, 3, 1'b0);
        fill(0);
        img_b[12] = 255;
        play_frame(2'd3, 2'd3, 3, 1'b0);
        drain();

        // Same random gaussian frame without and with backpressure
        fill_rand(0);
        play_frame(2'd2, 2'd2, 2, 1'b1);
        drain();
        bp_en = 1'b1;
        play_frame(2'd2, 2'd2, 2, 1'b1);
        drain();

        // Mode switched mid-frame takes effect only on the next frame
        fill_rand(0);
        play_frame(2'd1, 2'd3, 1, 1'b1);
        play_frame(2'd3, 2'd3, 3, 1'b1);
        drain();
        bp_en = 1'b0;
        drain();

        // Reset in the middle of a frame, then a clean sharpen frame
        fill_rand(1);
        for (int i = 0; i < 15; i++) begin
            mode = 2'd0;
            if ((i / 5) >= 2 && (i % 5) >= 2) push_b(img_b[i - 6], 1'b0);
            send(8'(img_b[i]));
        end
        in_valid = 1'b0;
        #1 rst_n = 1'b0;
        #1;
        check("midrst_out_valid", int'(out_valid), 0);
        check("midrst_out_pixel", int'(out_pixel), 0);
        check("midrst_out_last", int'(out_last), 0);
        check("midrst_in_ready", int'(in_ready), 1);
        q_b.delete();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        fill_rand(0);
        play_frame(2'd1, 2'd1, 1, 1'b1);
        drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/conv3x3_stream.md
# conv3x3_stream

Streaming 3×3 convolution engine; the parametrised successor to conv33. It accepts a raster-order pixel stream over a valid/ready handshake, keeps two internal line buffers, and builds each 3×3 window itself, so the driver no longer supplies three row taps or clears state at row ends. For each full window it emits one filtered pixel, giving an (IMG_W−2)×(IMG_H−2) output stream with backpressure and end-of-frame marking.

## Interface
- PIXEL_WIDTH, 8: unsigned pixel width, in and out.
- IMG_W, 252: pixels per line (≥3); line-buffer depth.
- IMG_H, 252: lines per frame (≥3).
- clk  in  1  clock; all state on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- mode  in  2  kernel select: 0 pass, 1 sharpen, 2 gaussian, 3 edge.
- in_valid  in  1  input pixel valid.
- in_ready  out  1  engine can accept in_pixel.
- in_pixel  in  PIXEL_WIDTH  raster-order input pixel.
- out_valid  out  1  out_pixel valid.
- out_ready  in  1  downstream accepts out_pixel.
- out_pixel  out  PIXEL_WIDTH  filtered pixel, clamped to 0..2^PIXEL_WIDTH−1.
- out_last  out  1  qualifies the final output pixel of a frame.

## Operation
- Accept = in_valid && in_ready. All state advances only on accept.
- Counters col (0..IMG_W−1) and row (0..IMG_H−1) give the position of the accepted pixel.
  - col wraps to 0 at IMG_W−1 and row increments.
  - At (IMG_H−1, IMG_W−1) both wrap to 0.
- Line buffers lb0 (previous line) and lb1 (two lines back) are IMG_W deep, with combinational read.
  - On accept at col c the new window column is {top=lb1[c], mid=lb0[c], bot=in_pixel}.
  - Same edge: lb1[c]←lb0[c], lb0[c]←in_pixel.
- Window: three column registers. On accept, shift left and load the new column into the right slot.
- Output condition: an accept with row≥2 && col≥2 produces a result from {two stored columns + the new column}.
  - Stale columns from the previous line are shifted out before col=2, so no per-line clear is needed.
- Mode is latched when the pixel at (0,0) is accepted and held for the whole frame. mode changes mid-frame are ignored.
- Kernels, rows listed top to bottom:
  - pass: centre pixel.
  - sharpen: [0 −1 0; −1 5 −1; 0 −1 0].
  - gaussian: [1 2 1; 2 4 2; 1 2 1], result = (sum+8)>>4.
  - edge: [−1 −1 −1; −1 8 −1; −1 −1 −1].
- Arithmetic: signed accumulation of PIXEL_WIDTH+5 bits, then clamp: <0 → 0, >max → max.
- out_last=1 with the result produced by the accept at (IMG_H−1, IMG_W−1).

## Timing
- Reset (async, immediate):
  - out_valid=0, out_pixel=0, out_last=0.
  - row=col=0, latched mode=0, window regs cleared.
  - Line-buffer contents need not be reset.
- in_ready = !out_valid || out_ready (combinational; single output register).
- Latency: the result appears with out_valid=1 in the cycle after its accepting edge.
- Output register:
  - Loads on an accept that meets the output condition; sets out_valid.
  - Clears out_valid when out_ready=1 and no new result is loaded on that edge.
  - Drain and load on the same edge: new data replaces old and out_valid stays 1.
- Stall: while out_valid && !out_ready:
  - in_ready=0; out_pixel and out_last are held stable.
  - Counters, buffers and window are frozen.
- Accepts that do not meet the output condition (row<2 or col<2) never touch the output register.
- Sustained throughput: 1 pixel/cycle when out_ready is held 1.
- Back-to-back frames need no idle gap. The first pixel of the next frame may be accepted on the edge after the last pixel.
- Reset mid-frame: the partial frame is discarded. The next accepted pixel is (0,0), and a following full frame is bit-exact.

## Test plan
- Reset: assert rst_n=0 mid-stream, with no clock edge → out_valid=0, out_pixel=0, out_last=0, in_ready=1 immediately.
- Pass, IMG_W=5, IMG_H=4, ramp input pixel=index 0..19 → outputs 6,7,8,11,12,13 in order; out_last only on 13; exactly 6 out_valid beats.
- Gaussian and sharpen, constant 100 frame → every output 100. Edge, constant frame → every output 0.
- Clamp, edge mode, single 255 pixel at (2,2) in a 0 frame (IMG_W=IMG_H=5) → output at centre (2,2) = 255 (8·255 clamped). Its 8 neighbours output 0 (−255 clamped).
- Backpressure: random out_ready (≈50%) with in_valid held 1 → output sequence identical to the out_ready=1 run. While stalled, no accept occurs and out_pixel is held stable.
- Mode and framing:
  - mode toggled 1→3 mid-frame → the whole frame uses sharpen; the next frame uses edge.
  - Two back-to-back frames with no gap → both are correct.
  - Reset mid-frame then a full frame → matches the golden model.
